pid_sequencer: RTL and testbench
================================

// Module: pid_sequencer
// PURPOSE
//  Drains the receiver's PID-order FIFO (8-bit entries, first-word-fall-through head) and sequences
//  downstream handling of each packet in arrival order. Each PID is validated, classified and routed:
//  DATA0/DATA1 start a data-FIFO drain, tokens go to the token handler, handshakes to the ACK path.
//  Sits between the USB receiver FIFOs and the AES encryptor front-end.
// PARAMETERS
//  TIMEOUT_W   8    width of data-drain watchdog counter; timeout = 2**TIMEOUT_W-1 cycles
//  ERR_CNT_W   8    width of saturating PID error counter (CONFIGURATION)
// PORTS
//  clk          in   1   system clock
//  n_rst        in   1   asynchronous active-low reset
//  pid_empty    in   1   PID FIFO empty
//  pid_rdata    in   8   PID FIFO head word, valid whenever !pid_empty
//  pid_r_enable out  1   pop PID FIFO (one-cycle pulse)
//  data_req     out  1   request downstream to drain one data packet from the data FIFO
//  data_done    in   1   downstream finished draining (pulse)
//  data_abort   out  1   one-cycle pulse: watchdog expired, drop current data packet
//  data_toggle  out  1   DATA PID of current packet (0=DATA0, 1=DATA1)
//  tok_valid    out  1   token PID presented on pid_out
//  tok_ready    in   1   token handler accepts
//  hs_valid     out  1   handshake PID presented on pid_out
//  hs_ready     in   1   handshake handler accepts
//  pid_out      out  4   latched PID[3:0]
//  pid_err      out  1   one-cycle pulse: PID check failed (PID[7:4] != ~PID[3:0]) or reserved PID
//  err_cnt      out  ERR_CNT_W  saturating error count (0 when macro absent)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pid_out=0, data_toggle=0, err_cnt=0, watchdog=0.
//  States: IDLE, DECODE, DATA, TOKEN, HS.
//  IDLE: if !pid_empty -> latch pid_rdata, pid_r_enable=1 same cycle, -> DECODE. Else stay.
//  DECODE (1 cycle): check fails or PID reserved -> pid_err=1, -> IDLE.
//   DATA0(0x3)/DATA1(0xB) -> DATA; DATA2/MDATA treated as reserved.
//   OUT/IN/SOF/SETUP (0x1,0x9,0x5,0xD) -> TOKEN. ACK/NAK/STALL (0x2,0xA,0xE) -> HS.
//   Other PIDs (PRE/ERR, SPLIT, PING, NYET) treated as reserved.
//  DATA: data_req held high; watchdog increments each cycle. data_done -> drop req, -> IDLE.
//   Watchdog reaching all-ones without data_done -> data_abort pulse, pid_err pulse, -> IDLE.
//   data_done and timeout same cycle: done wins, no abort.
//   Watchdog cleared on DATA entry.
//  TOKEN/HS: valid held with pid_out stable until ready; on valid&ready -> IDLE.
//  Latency: head PID to data_req/tok_valid/hs_valid = 2 cycles; min 3 cycles per PID (IDLE->DECODE->x->IDLE).
//  Never pops in a cycle with pid_empty=1; at most one pop per PID; no pop outside IDLE.
//  Reset mid-operation: state returns to IDLE immediately; latched PID discarded.
//   Popped-but-unhandled PID is lost.
// CONFIGURATION
//  PID_ERR_CNT_EN defined: err_cnt increments on every pid_err pulse, saturates at all-ones.
//  PID_ERR_CNT_EN undefined: no counter registers; err_cnt tied to 0.
// STRUCTURE
//  usb_pid_pkg: pid_t enum (4-bit PID codes), pid_class_t {CLS_DATA,CLS_TOKEN,CLS_HS,CLS_BAD},
//   seq_state_t enum.
//  Sub-module pid_check: combinational 8-bit -> {valid, pid_class_t}.
// TESTING
//  1. Push 0xC3 (DATA0), assert data_done 5 cycles after data_req.
//     -> one pop, data_req 2 cycles after push, data_toggle=0, return IDLE.
//  2. Push 0xE1 (OUT), hold tok_ready low 4 cycles.
//     -> tok_valid high with pid_out=0x1 stable; drops the cycle after tok_ready.
//  3. Push 0x55 (bad check).
//     -> pid_err pulse, no req/valid, err_cnt=1 with PID_ERR_CNT_EN, 0 without.
//  4. Push 0x4B (DATA1), never assert data_done.
//     -> data_abort + pid_err at 255 cycles (TIMEOUT_W=8), next PID then serviced.
//  5. Back-to-back 0xD2 (ACK), 0x69 (IN), 0xC3 (DATA0).
//     -> serviced in order hs, tok, data; exactly three pops; no pop while empty.
//  6. Assert n_rst low during DATA.
//     -> all outputs 0 asynchronously; after release, next FIFO PID handled normally.

Source files
------------

// File: rtl/pid_sequencer_pkg.sv
// Shared types for the PID sequencer.
//   pid_t        : 4-bit USB PID codes (low nibble of the PID byte)
//   pid_class_t  : routing class assigned to a decoded PID
//   seq_state_t  : sequencer FSM states
//   pid_check_ok : upper nibble must be the one's complement of the lower nibble
package pid_sequencer_pkg;

  typedef enum logic [3:0] {
    PID_RSVD  = 4'h0,
    PID_OUT   = 4'h1,
    PID_ACK   = 4'h2,
    PID_DATA0 = 4'h3,
    PID_PING  = 4'h4,
    PID_SOF   = 4'h5,
    PID_NYET  = 4'h6,
    PID_DATA2 = 4'h7,
    PID_SPLIT = 4'h8,
    PID_IN    = 4'h9,
    PID_NAK   = 4'hA,
    PID_DATA1 = 4'hB,
    PID_PRE   = 4'hC,
    PID_SETUP = 4'hD,
    PID_STALL = 4'hE,
    PID_MDATA = 4'hF
  } pid_t;

  typedef enum logic [1:0] {
    CLS_DATA,
    CLS_TOKEN,
    CLS_HS,
    CLS_BAD
  } pid_class_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_DATA,
    ST_TOKEN,
    ST_HS
  } seq_state_t;

  function automatic logic pid_check_ok(input logic [7:0] raw);
    return raw[7:4] == ~raw[3:0];
  endfunction

endpackage

// File: rtl/pid_sequencer_if.sv
// Bus bundle between the PID sequencer and its surroundings.
//   master : the sequencer (pops PID FIFO, drives data/token/handshake requests)
//   slave  : the environment (PID FIFO head, downstream handlers)
// Signals:
//   pid_empty/pid_rdata/pid_r_enable : first-word-fall-through PID FIFO read port
//   data_req/data_done/data_abort/data_toggle : data-FIFO drain request
//   tok_valid/tok_ready, hs_valid/hs_ready     : token / handshake handoff
//   pid_out : latched PID[3:0];  pid_err : error pulse;  err_cnt : error count
interface pid_sequencer_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 pid_empty;
  logic [7:0]           pid_rdata;
  logic                 pid_r_enable;
  logic                 data_req;
  logic                 data_done;
  logic                 data_abort;
  logic                 data_toggle;
  logic                 tok_valid;
  logic                 tok_ready;
  logic                 hs_valid;
  logic                 hs_ready;
  logic [3:0]           pid_out;
  logic                 pid_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    input  pid_empty, pid_rdata, data_done, tok_ready, hs_ready,
    output pid_r_enable, data_req, data_abort, data_toggle,
           tok_valid, hs_valid, pid_out, pid_err, err_cnt
  );

  modport slave (
    output pid_empty, pid_rdata, data_done, tok_ready, hs_ready,
    input  pid_r_enable, data_req, data_abort, data_toggle,
           tok_valid, hs_valid, pid_out, pid_err, err_cnt
  );
endinterface

// File: rtl/pid_sequencer_check.sv
// Combinational PID validator / classifier.
//   raw   : 8-bit PID byte
//   valid : check nibble matches (raw[7:4] == ~raw[3:0])
//   cls   : routing class; DATA2/MDATA and all non-routed PIDs are CLS_BAD
module pid_sequencer_check
  import pid_sequencer_pkg::*;
(
  input  logic [7:0] raw,
  output logic       valid,
  output pid_class_t cls
);

  always_comb begin
    valid = pid_check_ok(raw);
    case (pid_t'(raw[3:0]))
      PID_DATA0, PID_DATA1:                   cls = CLS_DATA;
      PID_OUT, PID_IN, PID_SOF, PID_SETUP:    cls = CLS_TOKEN;
      PID_ACK, PID_NAK, PID_STALL:            cls = CLS_HS;
      default:                                cls = CLS_BAD;
    endcase
  end

endmodule

// File: rtl/pid_sequencer.sv
// PID sequencer: drains the receiver's PID-order FIFO one entry at a time and
// routes each PID (data drain, token handler, handshake path) in arrival order.
// Ports:
//   clk   : system clock
//   n_rst : asynchronous active-low reset
//   bus   : pid_sequencer_if.master (PID FIFO read, data/token/hs handoff, errors)
// Parameters:
//   TIMEOUT_W : data-drain watchdog width; abort after 2**TIMEOUT_W-1 cycles
//   ERR_CNT_W : width of the saturating error counter
// Build option:
//   PID_ERR_CNT_EN : when defined, err_cnt counts pid_err pulses (saturating);
//                    otherwise no counter exists and err_cnt is tied to 0.
module pid_sequencer
  import pid_sequencer_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic clk,
  input  logic n_rst,
  pid_sequencer_if.master bus
);

  seq_state_t           state, next_state;
  logic [7:0]           pid_q;
  logic                 toggle_q;
  logic [TIMEOUT_W-1:0] wd_q;
  logic                 wd_full;
  logic                 chk_valid;
  pid_class_t           chk_cls;
  logic                 pid_bad;
  logic                 pop;
  logic                 abort;
  logic                 err_pulse;

  pid_sequencer_check u_check (
    .raw   (pid_q),
    .valid (chk_valid),
    .cls   (chk_cls)
  );

  assign pid_bad = !chk_valid || (chk_cls == CLS_BAD);
  assign wd_full = &wd_q;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (!bus.pid_empty) next_state = ST_DECODE;
      ST_DECODE: begin
        if (pid_bad)                   next_state = ST_IDLE;
        else if (chk_cls == CLS_DATA)  next_state = ST_DATA;
        else if (chk_cls == CLS_TOKEN) next_state = ST_TOKEN;
        else                           next_state = ST_HS;
      end
      // data_done and a full watchdog both return to IDLE; done only suppresses the abort
      ST_DATA:   if (bus.data_done || wd_full) next_state = ST_IDLE;
      ST_TOKEN:  if (bus.tok_ready) next_state = ST_IDLE;
      ST_HS:     if (bus.hs_ready)  next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Output logic; the pop is gated by reset so nothing is lost while held in reset
  always_comb begin
    pop       = (state == ST_IDLE) && !bus.pid_empty && n_rst;
    abort     = (state == ST_DATA) && wd_full && !bus.data_done;
    err_pulse = ((state == ST_DECODE) && pid_bad) || abort;
  end

  assign bus.pid_r_enable = pop;
  assign bus.data_req     = (state == ST_DATA);
  assign bus.data_abort   = abort;
  assign bus.tok_valid    = (state == ST_TOKEN);
  assign bus.hs_valid     = (state == ST_HS);
  assign bus.pid_err      = err_pulse;
  assign bus.pid_out      = pid_q[3:0];
  assign bus.data_toggle  = toggle_q;

  // Latched PID, data toggle and watchdog
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pid_q    <= '0;
      toggle_q <= 1'b0;
      wd_q     <= '0;
    end else begin
      if (pop) pid_q <= bus.pid_rdata;
      if ((state == ST_DECODE) && (next_state == ST_DATA)) toggle_q <= pid_q[3];
      // Watchdog sits at zero outside DATA, so every DATA entry starts from zero
      if (state == ST_DATA) wd_q <= wd_q + TIMEOUT_W'(1);
      else                  wd_q <= '0;
    end
  end

`ifdef PID_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                         err_cnt_q <= '0;
    else if (err_pulse && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_pid_sequencer.sv
// Directed testbench for pid_sequencer: a small FIFO model feeds PID bytes,
// each task drives one scenario and checks outputs on the falling clock edge.
module tb_pid_sequencer;
  localparam int TW = 8;
  localparam int EW = 8;
`ifdef PID_ERR_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  pid_sequencer_if #(.ERR_CNT_W(EW)) sif ();

  pid_sequencer #(.TIMEOUT_W(TW), .ERR_CNT_W(EW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (sif)
  );

  // PID FIFO model (first-word-fall-through)
  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  int bad_pops = 0;
  assign sif.pid_empty = (wr_ptr == rd_ptr);
  assign sif.pid_rdata = mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (sif.pid_r_enable) begin
      if (wr_ptr == rd_ptr) bad_pops <= bad_pops + 1;
      else begin
        rd_ptr <= rd_ptr + 1;
        pops   <= pops + 1;
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic push(input logic [7:0] v);
    mem[wr_ptr[3:0]] = v;
    wr_ptr++;
  endtask

  task automatic test_reset;
    #2;
    total++; if (sif.pid_r_enable !== 1'b0) begin bad++; $display("FAIL rst_pop: got %b want 0", sif.pid_r_enable); end
    total++; if ({sif.data_req, sif.data_abort, sif.data_toggle, sif.tok_valid, sif.hs_valid, sif.pid_err} !== 6'b0) begin bad++; $display("FAIL rst_ctrl: got %b want 000000", {sif.data_req, sif.data_abort, sif.data_toggle, sif.tok_valid, sif.hs_valid, sif.pid_err}); end
    total++; if (sif.pid_out !== 4'h0) begin bad++; $display("FAIL rst_pid_out: got %h want 0", sif.pid_out); end
    total++; if (sif.err_cnt !== 8'd0) begin bad++; $display("FAIL rst_err_cnt: got %0d want 0", sif.err_cnt); end
    @(negedge clk); n_rst = 1'b1;
    @(negedge clk);
    total++; if (sif.data_req !== 1'b0 || sif.pid_r_enable !== 1'b0) begin bad++; $display("FAIL rst_idle: req=%b pop=%b want 0 0", sif.data_req, sif.pid_r_enable); end
  endtask

  task automatic test_data0;
    int p0;
    p0 = pops;
    push(8'hC3); #1;
    total++; if (sif.pid_r_enable !== 1'b1) begin bad++; $display("FAIL t1_pop_now: got %b want 1", sif.pid_r_enable); end
    @(negedge clk);
    total++; if (sif.data_req !== 1'b0) begin bad++; $display("FAIL t1_req_early: got %b want 0", sif.data_req); end
    @(negedge clk);
    total++; if (sif.data_req !== 1'b1) begin bad++; $display("FAIL t1_req_rise: got %b want 1", sif.data_req); end
    total++; if (sif.data_toggle !== 1'b0) begin bad++; $display("FAIL t1_toggle: got %b want 0", sif.data_toggle); end
    total++; if (pops !== p0 + 1) begin bad++; $display("FAIL t1_one_pop: got %0d want %0d", pops - p0, 1); end
    repeat (5) @(negedge clk);
    sif.data_done = 1'b1; #1;
    total++; if (sif.data_req !== 1'b1 || sif.data_abort !== 1'b0) begin bad++; $display("FAIL t1_req_hold: req=%b abort=%b want 1 0", sif.data_req, sif.data_abort); end
    @(negedge clk); sif.data_done = 1'b0;
    total++; if (sif.data_req !== 1'b0) begin bad++; $display("FAIL t1_req_drop: got %b want 0", sif.data_req); end
    total++; if (pops !== p0 + 1 || sif.pid_r_enable !== 1'b0) begin bad++; $display("FAIL t1_idle: pops=%0d pop=%b want 1 0", pops - p0, sif.pid_r_enable); end
  endtask

  task automatic test_token;
    push(8'hE1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++; if (sif.tok_valid !== 1'b1 || sif.pid_out !== 4'h1) begin bad++; $display("FAIL t2_tok_hold%0d: valid=%b pid=%h want 1 1", i, sif.tok_valid, sif.pid_out); end
      if (i < 3) @(negedge clk);
    end
    total++; if (sif.hs_valid !== 1'b0 || sif.data_req !== 1'b0) begin bad++; $display("FAIL t2_other: hs=%b req=%b want 0 0", sif.hs_valid, sif.data_req); end
    @(negedge clk);
    sif.tok_ready = 1'b1; #1;
    total++; if (sif.tok_valid !== 1'b1) begin bad++; $display("FAIL t2_tok_at_ready: got %b want 1", sif.tok_valid); end
    @(negedge clk); sif.tok_ready = 1'b0;
    total++; if (sif.tok_valid !== 1'b0) begin bad++; $display("FAIL t2_tok_drop: got %b want 0", sif.tok_valid); end
  endtask

  task automatic test_bad_pid;
    push(8'h55);
    @(negedge clk);
    total++; if (sif.pid_err !== 1'b1) begin bad++; $display("FAIL t3_err_pulse: got %b want 1", sif.pid_err); end
    @(negedge clk);
    total++; if (sif.pid_err !== 1'b0) begin bad++; $display("FAIL t3_err_end: got %b want 0", sif.pid_err); end
    total++; if ({sif.data_req, sif.tok_valid, sif.hs_valid} !== 3'b0) begin bad++; $display("FAIL t3_no_route: got %b want 000", {sif.data_req, sif.tok_valid, sif.hs_valid}); end
    total++; if (sif.err_cnt !== 8'(CNT_EN)) begin bad++; $display("FAIL t3_err_cnt: got %0d want %0d", sif.err_cnt, CNT_EN); end
    // DATA2 passes the check nibble but is reserved
    push(8'h87);
    @(negedge clk);
    total++; if (sif.pid_err !== 1'b1) begin bad++; $display("FAIL t3_rsvd_err: got %b want 1", sif.pid_err); end
    @(negedge clk);
    total++; if ({sif.data_req, sif.tok_valid, sif.hs_valid} !== 3'b0) begin bad++; $display("FAIL t3_rsvd_route: got %b want 000", {sif.data_req, sif.tok_valid, sif.hs_valid}); end
    total++; if (sif.err_cnt !== 8'(2 * CNT_EN)) begin bad++; $display("FAIL t3_err_cnt2: got %0d want %0d", sif.err_cnt, 2 * CNT_EN); end
  endtask

  task automatic test_timeout;
    int n;
    push(8'h4B);
    repeat (2) @(negedge clk);
    total++; if (sif.data_req !== 1'b1 || sif.data_toggle !== 1'b1) begin bad++; $display("FAIL t4_req: req=%b toggle=%b want 1 1", sif.data_req, sif.data_toggle); end
    n = 0;
    while (n < 300 && sif.data_abort !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    total++; if (n !== 255) begin bad++; $display("FAIL t4_abort_cycles: got %0d want 255", n); end
    total++; if (sif.pid_err !== 1'b1) begin bad++; $display("FAIL t4_abort_err: got %b want 1", sif.pid_err); end
    @(negedge clk);
    total++; if (sif.data_req !== 1'b0 || sif.data_abort !== 1'b0) begin bad++; $display("FAIL t4_after: req=%b abort=%b want 0 0", sif.data_req, sif.data_abort); end
    total++; if (sif.err_cnt !== 8'(3 * CNT_EN)) begin bad++; $display("FAIL t4_err_cnt: got %0d want %0d", sif.err_cnt, 3 * CNT_EN); end
    push(8'h5A);
    repeat (2) @(negedge clk);
    total++; if (sif.hs_valid !== 1'b1 || sif.pid_out !== 4'hA) begin bad++; $display("FAIL t4_next_pid: hs=%b pid=%h want 1 a", sif.hs_valid, sif.pid_out); end
    sif.hs_ready = 1'b1;
    @(negedge clk); sif.hs_ready = 1'b0;
    total++; if (sif.hs_valid !== 1'b0) begin bad++; $display("FAIL t4_hs_drop: got %b want 0", sif.hs_valid); end
  endtask

  task automatic test_done_vs_timeout;
    push(8'hC3);
    repeat (2) @(negedge clk);
    total++; if (sif.data_toggle !== 1'b0) begin bad++; $display("FAIL t4b_toggle: got %b want 0", sif.data_toggle); end
    repeat (255) @(negedge clk);
    sif.data_done = 1'b1; #1;
    total++; if (sif.data_abort !== 1'b0 || sif.pid_err !== 1'b0) begin bad++; $display("FAIL t4b_done_wins: abort=%b err=%b want 0 0", sif.data_abort, sif.pid_err); end
    @(negedge clk); sif.data_done = 1'b0;
    total++; if (sif.data_req !== 1'b0) begin bad++; $display("FAIL t4b_req_drop: got %b want 0", sif.data_req); end
    total++; if (sif.err_cnt !== 8'(3 * CNT_EN)) begin bad++; $display("FAIL t4b_err_cnt: got %0d want %0d", sif.err_cnt, 3 * CNT_EN); end
  endtask

  task automatic test_back_to_back;
    int p0, n;
    p0 = pops;
    push(8'hD2); push(8'h69); push(8'hC3);
    n = 0;
    while (n < 10 && sif.hs_valid !== 1'b1) begin @(negedge clk); n++; end
    total++; if (n !== 2) begin bad++; $display("FAIL t5_hs_latency: got %0d want 2", n); end
    total++; if (sif.pid_out !== 4'h2 || sif.tok_valid !== 1'b0 || pops !== p0 + 1) begin bad++; $display("FAIL t5_hs: pid=%h tok=%b pops=%0d want 2 0 1", sif.pid_out, sif.tok_valid, pops - p0); end
    sif.hs_ready = 1'b1;
    @(negedge clk); sif.hs_ready = 1'b0;
    n = 0;
    while (n < 10 && sif.tok_valid !== 1'b1) begin @(negedge clk); n++; end
    total++; if (sif.tok_valid !== 1'b1 || sif.pid_out !== 4'h9 || pops !== p0 + 2) begin bad++; $display("FAIL t5_tok: valid=%b pid=%h pops=%0d want 1 9 2", sif.tok_valid, sif.pid_out, pops - p0); end
    sif.tok_ready = 1'b1;
    @(negedge clk); sif.tok_ready = 1'b0;
    n = 0;
    while (n < 10 && sif.data_req !== 1'b1) begin @(negedge clk); n++; end
    total++; if (sif.data_req !== 1'b1 || sif.data_toggle !== 1'b0 || pops !== p0 + 3) begin bad++; $display("FAIL t5_data: req=%b toggle=%b pops=%0d want 1 0 3", sif.data_req, sif.data_toggle, pops - p0); end
    sif.data_done = 1'b1;
    @(negedge clk); sif.data_done = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (pops !== p0 + 3 || bad_pops !== 0) begin bad++; $display("FAIL t5_pops: pops=%0d empty_pops=%0d want 3 0", pops - p0, bad_pops); end
    total++; if (sif.data_req !== 1'b0 || sif.pid_empty !== 1'b1) begin bad++; $display("FAIL t5_end: req=%b empty=%b want 0 1", sif.data_req, sif.pid_empty); end
  endtask

  task automatic test_reset_mid;
    int p0;
    push(8'hC3);
    repeat (2) @(negedge clk);
    total++; if (sif.data_req !== 1'b1) begin bad++; $display("FAIL t6_req: got %b want 1", sif.data_req); end
    push(8'hE1);
    p0 = pops;
    #2 n_rst = 1'b0; #1;
    total++; if ({sif.data_req, sif.pid_r_enable, sif.data_toggle, sif.tok_valid, sif.hs_valid, sif.pid_err} !== 6'b0) begin bad++; $display("FAIL t6_async_ctrl: got %b want 000000", {sif.data_req, sif.pid_r_enable, sif.data_toggle, sif.tok_valid, sif.hs_valid, sif.pid_err}); end
    total++; if (sif.pid_out !== 4'h0 || sif.err_cnt !== 8'd0) begin bad++; $display("FAIL t6_async_regs: pid=%h cnt=%0d want 0 0", sif.pid_out, sif.err_cnt); end
    @(negedge clk);
    total++; if (pops !== p0) begin bad++; $display("FAIL t6_no_pop_in_rst: got %0d want 0", pops - p0); end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (sif.tok_valid !== 1'b1 || sif.pid_out !== 4'h1 || pops !== p0 + 1) begin bad++; $display("FAIL t6_after_rst: tok=%b pid=%h pops=%0d want 1 1 1", sif.tok_valid, sif.pid_out, pops - p0); end
    sif.tok_ready = 1'b1;
    @(negedge clk); sif.tok_ready = 1'b0;
    total++; if (sif.tok_valid !== 1'b0 || bad_pops !== 0) begin bad++; $display("FAIL t6_end: tok=%b empty_pops=%0d want 0 0", sif.tok_valid, bad_pops); end
  endtask

  initial begin
    sif.data_done = 1'b0;
    sif.tok_ready = 1'b0;
    sif.hs_ready  = 1'b0;
    test_reset;
    test_data0;
    test_token;
    test_bad_pid;
    test_timeout;
    test_done_vs_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench did not finish");
  end

endmodule
